cluster_collector: RTL and testbench

- Sits directly downstream of the 768-pad priority encoder.
- Each cycle the encoder presents at most one cluster (cluster_found, adr, cnt). This block samples those results over a fixed per-bunch-crossing window and packs up to MXCLUSTERS of them into one parallel frame for the output formatter.
- Marks unused slots with the empty-cluster code and flags overflow when the window yields more clusters than the frame has slots.

---
 rtl/cluster_collector.sv | 126 ++++++++++++
 tb/tb_cluster_collector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cluster_collector.sv
// Packs up to MXCLUSTERS encoder results from one bunch-crossing window into a parallel frame.
// Unused slots carry the empty-cluster code. Overflow flags clusters dropped once all slots are full. Assumes WINDOW >= 2.
module cluster_collector #(
   parameter int                MXCLUSTERS = 8,
   parameter int                WINDOW     = 4,
   parameter int                MXADRB     = 11,
   parameter int                MXCNTB     = 3,
   parameter logic [MXADRB-1:0] EMPTY_ADR  = MXADRB'(11'h7FE)
) (
   input  logic                                   clock,
   input  logic                                   global_reset,
   input  logic                                   frame_start,
   input  logic                                   cluster_found,
   input  logic [MXADRB-1:0]                      adr,
   input  logic [MXCNTB-1:0]                      cnt,
   output logic [MXCLUSTERS*(MXADRB+MXCNTB)-1:0]  clusters_out,
   output logic                                   clusters_valid,
   output logic [3:0]                             n_clusters,
   output logic                                   overflow
);
   localparam int SLOTW = MXADRB + MXCNTB;
   localparam int WCB   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int SIB   = $clog2(MXCLUSTERS + 1);
   localparam logic [SLOTW-1:0] EMPTY_SLOT = {{MXCNTB{1'b0}}, EMPTY_ADR};
   localparam logic [WCB-1:0]   WC_LAST    = WCB'(WINDOW - 1);
   localparam logic [SIB-1:0]   SI_FULL    = SIB'(MXCLUSTERS);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t           state, state_next;
   logic [WCB-1:0]   wc, wc_next;
   logic [SLOTW-1:0] work [MXCLUSTERS];
   logic [SLOTW-1:0] acc  [MXCLUSTERS];
   logic [SIB-1:0]   si, acc_si;
   logic             work_ovf, acc_ovf;
   logic             take, pub_early, pub_end;

   always_ff @(posedge clock) begin
      if (global_reset) begin
         state <= IDLE;
         wc    <= '0;
      end else begin
         state <= state_next;
         wc    <= wc_next;
      end
   end

   always_comb begin
      state_next = state;
      wc_next    = wc;
      unique case (state)
         IDLE: begin
            if (frame_start) begin
               state_next = COLLECT;
               wc_next    = WCB'(1);
            end
         end
         COLLECT: begin
            if (frame_start) begin
               wc_next = WCB'(1);
            end else if (wc == WC_LAST) begin
               state_next = IDLE;
               wc_next    = '0;
            end else begin
               wc_next = wc + 1'b1;
            end
         end
      endcase
   end

   // acc is the working frame after this cycle's sample; a frame_start restarts it from empty.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      take      = frame_start || (state == COLLECT);
      pub_early = (state == COLLECT) && frame_start;
      pub_end   = (state == COLLECT) && !frame_start && (wc == WC_LAST);
      acc_si    = frame_start ? '0 : si;
      acc_ovf   = frame_start ? 1'b0 : work_ovf;
      for (int k = 0; k < MXCLUSTERS; k++) begin
         acc[k] = frame_start ? EMPTY_SLOT : work[k];
      end
      if (take && cluster_found) begin
         if (acc_si < SI_FULL) begin
            for (int k = 0; k < MXCLUSTERS; k++) begin
               if (SIB'(k) == acc_si) acc[k] = {cnt, adr};
            end
            acc_si = acc_si + 1'b1;
         end else begin
            acc_ovf = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (global_reset) begin
         // NOTE: the slot storage is reset on purpose; unused slots must read as the empty code.
         for (int k = 0; k < MXCLUSTERS; k++) work[k] <= EMPTY_SLOT;
         si             <= '0;
         work_ovf       <= 1'b0;
         clusters_out   <= {MXCLUSTERS{EMPTY_SLOT}};
         clusters_valid <= 1'b0;
         n_clusters     <= 4'd0;
         overflow       <= 1'b0;
      end else begin
         clusters_valid <= pub_early || pub_end;
         if (pub_early) begin
            for (int k = 0; k < MXCLUSTERS; k++) clusters_out[k*SLOTW +: SLOTW] <= work[k];
            n_clusters <= 4'(si);
            overflow   <= work_ovf;
         end else if (pub_end) begin
            for (int k = 0; k < MXCLUSTERS; k++) clusters_out[k*SLOTW +: SLOTW] <= acc[k];
            n_clusters <= 4'(acc_si);
            overflow   <= acc_ovf;
         end
         if (pub_end) begin
            for (int k = 0; k < MXCLUSTERS; k++) work[k] <= EMPTY_SLOT;
            si       <= '0;
            work_ovf <= 1'b0;
         end else if (take) begin
            for (int k = 0; k < MXCLUSTERS; k++) work[k] <= acc[k];
            si       <= acc_si;
            work_ovf <= acc_ovf;
         end
      end
   end
endmodule

// File: tb/tb_cluster_collector.sv
// Self-checking bench for cluster_collector: directed vector table, hand sequences, and
// randomized stimulus compared against a queue-based frame model.
module tb_cluster_collector;
   localparam int WIN = 4;
   localparam logic [13:0] EMPTY = 14'h07FE;
   localparam logic [111:0] ALL_EMPTY = {8{EMPTY}};

   logic         clock = 1'b0;
   logic         global_reset = 1'b0, frame_start = 1'b0, cluster_found = 1'b0;
   logic [10:0]  adr = '0;
   logic [2:0]   cnt = '0;
   logic [111:0] clusters_out, out12;
   logic         clusters_valid, valid12, overflow, ovf12;
   logic [3:0]   n_clusters, n12;

   int checks = 0;
   int errors = 0;

   cluster_collector dut (
      .clock(clock), .global_reset(global_reset), .frame_start(frame_start),
      .cluster_found(cluster_found), .adr(adr), .cnt(cnt),
      .clusters_out(clusters_out), .clusters_valid(clusters_valid),
      .n_clusters(n_clusters), .overflow(overflow));

   cluster_collector #(.WINDOW(12)) dut12 (
      .clock(clock), .global_reset(global_reset), .frame_start(frame_start),
      .cluster_found(cluster_found), .adr(adr), .cnt(cnt),
      .clusters_out(out12), .clusters_valid(valid12),
      .n_clusters(n12), .overflow(ovf12));

   always #5 clock = ~clock;

   // Reference model: clusters of the open frame kept in a queue, published whole.
   bit           m_in, m_ovf;
   int           m_pos;
   logic [13:0]  m_q[$];
   logic         e_valid, e_ovf;
   logic [3:0]   e_n;
   logic [111:0] e_out;

   task automatic publish();
      e_valid = 1'b1;
      e_out   = ALL_EMPTY;
      foreach (m_q[i]) e_out[i*14 +: 14] = m_q[i];
      e_n   = 4'(m_q.size());
      e_ovf = m_ovf;
   endtask

   task automatic model_cycle(input logic rst, fs, found, input logic [10:0] a, input logic [2:0] c);
      if (rst) begin
         m_in = 0; m_ovf = 0; m_pos = 0; m_q.delete();
         e_valid = 0; e_ovf = 0; e_n = 0; e_out = ALL_EMPTY;
         return;
      end
      e_valid = 1'b0;
      if (m_in && fs) publish();
      if (fs) begin
         m_in = 1; m_pos = 0; m_ovf = 0; m_q.delete();
      end
      if (m_in) begin
         if (found) begin
            if (m_q.size() < 8) m_q.push_back({c, a});
            else m_ovf = 1;
         end
         if (m_pos == WIN - 1) begin
            publish();
            m_in = 0;
         end else begin
            m_pos++;
         end
      end
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge; outputs are sampled 1 ns after the next rising edge.
   task automatic step(input logic rst, fs, found, input logic [10:0] a, input logic [2:0] c);
      @(negedge clock);
      global_reset = rst; frame_start = fs; cluster_found = found; adr = a; cnt = c;
      model_cycle(rst, fs, found, a, c);
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, 128'(clusters_valid), 128'(0));
      check({tag, "_out"},   128'(clusters_out), 128'(ALL_EMPTY));
      check({tag, "_n"},     128'(n_clusters), 128'(0));
      check({tag, "_ovf"},   128'(overflow), 128'(0));
   endtask

   typedef struct {
      logic        fs, found;
      logic [10:0] a;
      logic [2:0]  c;
      logic        ev;
      logic [3:0]  en;
      logic        eo;
      logic [13:0] s0, s1;
   } vec_t;

   vec_t tbl[12];

   initial begin
      // Two directed frames: a normal window, then an early frame_start splitting two frames.
      tbl[0]  = '{1'b1, 1'b1, 11'd5,   3'd2, 1'b0, 4'd0, 1'b0, EMPTY, EMPTY};
      tbl[1]  = '{1'b0, 1'b0, 11'd0,   3'd0, 1'b0, 4'd0, 1'b0, EMPTY, EMPTY};
      tbl[2]  = '{1'b0, 1'b1, 11'd700, 3'd7, 1'b0, 4'd0, 1'b0, EMPTY, EMPTY};
      tbl[3]  = '{1'b0, 1'b0, 11'd0,   3'd0, 1'b1, 4'd2, 1'b0, 14'h1005, {3'd7, 11'd700}};
      tbl[4]  = '{1'b0, 1'b1, 11'd99,  3'd5, 1'b0, 4'd2, 1'b0, 14'h1005, {3'd7, 11'd700}};
      tbl[5]  = '{1'b1, 1'b0, 11'd0,   3'd0, 1'b0, 4'd2, 1'b0, 14'h1005, {3'd7, 11'd700}};
      tbl[6]  = '{1'b0, 1'b1, 11'd10,  3'd1, 1'b0, 4'd2, 1'b0, 14'h1005, {3'd7, 11'd700}};
      tbl[7]  = '{1'b1, 1'b1, 11'd20,  3'd3, 1'b1, 4'd1, 1'b0, {3'd1, 11'd10}, EMPTY};
      tbl[8]  = '{1'b0, 1'b0, 11'd0,   3'd0, 1'b0, 4'd1, 1'b0, {3'd1, 11'd10}, EMPTY};
      tbl[9]  = '{1'b0, 1'b0, 11'd0,   3'd0, 1'b0, 4'd1, 1'b0, {3'd1, 11'd10}, EMPTY};
      tbl[10] = '{1'b0, 1'b0, 11'd0,   3'd0, 1'b1, 4'd1, 1'b0, {3'd3, 11'd20}, EMPTY};
      tbl[11] = '{1'b0, 1'b0, 11'd0,   3'd0, 1'b0, 4'd1, 1'b0, {3'd3, 11'd20}, EMPTY};

      // Reset, then idle with cluster_found toggling: IDLE must ignore it.
      step(1, 0, 0, 0, 0);
      check_reset_state("rst");
      for (int i = 0; i < 10; i++) begin
         step(0, 0, i[0], 11'(i), 3'(i));
         check("idle_valid", 128'(clusters_valid), 128'(0));
      end
      check_reset_state("idle_end");

      foreach (tbl[i]) begin
         step(0, tbl[i].fs, tbl[i].found, tbl[i].a, tbl[i].c);
         check($sformatf("tbl%0d_valid", i), 128'(clusters_valid), 128'(tbl[i].ev));
         check($sformatf("tbl%0d_n", i),     128'(n_clusters), 128'(tbl[i].en));
         check($sformatf("tbl%0d_ovf", i),   128'(overflow), 128'(tbl[i].eo));
         check($sformatf("tbl%0d_out", i),   128'(clusters_out),
               128'({{6{EMPTY}}, tbl[i].s1, tbl[i].s0}));
      end

      // Reset in the middle of a frame holding one cluster: that frame is never published.
      step(0, 1, 1, 11'd33, 3'd1);
      check("mid_t0_valid", 128'(clusters_valid), 128'(0));
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check_reset_state("mid_rst");
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0, 0);
         check("mid_quiet_valid", 128'(clusters_valid), 128'(0));
      end
      check("mid_quiet_out", 128'(clusters_out), 128'(ALL_EMPTY));
      step(0, 1, 1, 11'd44, 3'd2);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("after_rst_valid", 128'(clusters_valid), 128'(1));
      check("after_rst_n", 128'(n_clusters), 128'(1));
      check("after_rst_out", 128'(clusters_out), 128'({{7{EMPTY}}, {3'd2, 11'd44}}));

      // Twelve-cycle window with a cluster every cycle: eight kept, the rest dropped.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         step(0, i == 0, 1, 11'(i), 3'(i));
         if (i == 10) check("w12_early_valid", 128'(valid12), 128'(0));
      end
      begin
         logic [111:0] exp12;
         for (int k = 0; k < 8; k++) exp12[k*14 +: 14] = {3'(k), 11'(k)};
         check("w12_valid", 128'(valid12), 128'(1));
         check("w12_n", 128'(n12), 128'(8));
         check("w12_ovf", 128'(ovf12), 128'(1));
         check("w12_out", 128'(out12), 128'(exp12));
      end
      for (int i = 0; i < 12; i++) step(0, i == 0, 0, 0, 0);
      check("w12_next_valid", 128'(valid12), 128'(1));
      check("w12_next_n", 128'(n12), 128'(0));
      check("w12_next_ovf", 128'(ovf12), 128'(0));
      check("w12_next_out", 128'(out12), 128'(ALL_EMPTY));

      // Randomized stimulus against the model, including occasional mid-frame resets.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         logic r, fs, fd;
         r  = ($urandom_range(0, 299) == 0);
         fs = ($urandom_range(0, 4) == 0);
         fd = ($urandom_range(0, 9) < 6);
         step(r, fs, fd, 11'($urandom), 3'($urandom));
         check("rnd_valid", 128'(clusters_valid), 128'(e_valid));
         check("rnd_n",     128'(n_clusters), 128'(e_n));
         check("rnd_ovf",   128'(overflow), 128'(e_ovf));
         check("rnd_out",   128'(clusters_out), 128'(e_out));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
